// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-RAM responder: FSM states, access direction, index slice.
// No logic; pure declarations.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    localparam int DATA_W     = 32;
    localparam int CPU_ADDR_W = 16;
    // Word index is the byte address with the two byte-lane bits dropped.
    localparam int IDX_LSB    = 2;
    localparam int IDX_W      = CPU_ADDR_W - IDX_LSB;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU memory-access bus plus loader/status signals of the data-RAM responder.
// master = CPU/loader side, slave = responder side.
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  MEM_ACCESS_READ_WRN;
    logic [15:0]           MEM_ACCESS_ADDRESS_BUS;
    logic [31:0]           MEM_ACCESS_DATA_OUT_BUS;
    logic [31:0]           MEM_ACCESS_DATA_IN_BUS;
    logic                  HALT;
    logic                  LOAD_REQ;
    logic                  LOAD_VALID;
    logic                  LOAD_READY;
    logic [ADDR_WIDTH-1:0] LOAD_ADDR;
    logic [31:0]           LOAD_DATA;
    logic                  LOAD_LAST;
    logic                  LOAD_DONE;
    logic                  MISALIGN_ERR;
    logic                  OOR_ERR;
    logic                  ERR_CLR;

    modport master (
        output MEM_ACCESS_READ_WRN, MEM_ACCESS_ADDRESS_BUS, MEM_ACCESS_DATA_OUT_BUS,
        output LOAD_REQ, LOAD_VALID, LOAD_ADDR, LOAD_DATA, LOAD_LAST, ERR_CLR,
        input  MEM_ACCESS_DATA_IN_BUS, HALT, LOAD_READY, LOAD_DONE, MISALIGN_ERR, OOR_ERR
    );

    modport slave (
        input  MEM_ACCESS_READ_WRN, MEM_ACCESS_ADDRESS_BUS, MEM_ACCESS_DATA_OUT_BUS,
        input  LOAD_REQ, LOAD_VALID, LOAD_ADDR, LOAD_DATA, LOAD_LAST, ERR_CLR,
        output MEM_ACCESS_DATA_IN_BUS, HALT, LOAD_READY, LOAD_DONE, MISALIGN_ERR, OOR_ERR
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// DEPTH x 32 word RAM: one synchronous write port, one asynchronous (zero-latency) read port.
// No backpressure; contents are deliberately not reset.
module data_mem_array #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-RAM responder: zero-latency CPU loads, CPU stores at the clock edge, loader port that halts the CPU.
// Loader beats accepted only in LOAD (LOAD_READY); the CPU is stalled via HALT from SETTLE to RELEASE.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int HALT_SETTLE = 1
) (
    input  logic                 CK_REF,
    input  logic                 RST_N,
    data_mem_responder_if.slave  bus
);

    localparam int         DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [1:0] SETTLE_LAST = 2'(HALT_SETTLE - 1);

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  via_last_q, via_last_d;
    logic                  misalign_q, oor_q;
    logic                  halt, load_rdy, load_done;

    logic [IDX_W-1:0]      cpu_idx;
    logic                  cpu_in_range, cpu_acc, cpu_we, ld_we, mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_W-1:0]     mem_wdata, mem_rdata;

    assign cpu_idx      = bus.MEM_ACCESS_ADDRESS_BUS[CPU_ADDR_W-1:IDX_LSB];
    assign cpu_in_range = ({{(32-IDX_W){1'b0}}, cpu_idx} < 32'(DEPTH));
    // The CPU parks at read/address 0 when it has nothing to do; that is not an access.
    assign cpu_acc      = (bus.MEM_ACCESS_READ_WRN == MEM_WRITE) || (bus.MEM_ACCESS_ADDRESS_BUS != '0);

    assign cpu_we    = (state_q == ST_IDLE) && (bus.MEM_ACCESS_READ_WRN == MEM_WRITE) && cpu_in_range;
    assign ld_we     = (state_q == ST_LOAD) && bus.LOAD_VALID;
    assign mem_we    = cpu_we || ld_we;
    assign mem_waddr = ld_we ? bus.LOAD_ADDR : cpu_idx[ADDR_WIDTH-1:0];
    assign mem_wdata = ld_we ? bus.LOAD_DATA : bus.MEM_ACCESS_DATA_OUT_BUS;

    data_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_W)
    ) u_array (
        .clk   (CK_REF),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (cpu_idx[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            via_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            via_last_q <= via_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        via_last_d = via_last_q;
        halt       = 1'b1;
        load_rdy   = 1'b0;
        load_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                halt       = 1'b0;
                cnt_d      = 2'd0;
                via_last_d = 1'b0;
                if (bus.LOAD_REQ) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_d = ST_LOAD;
                else                      cnt_d   = cnt_q + 2'd1;
            end
            ST_LOAD: begin
                load_rdy = 1'b1;
                // A LAST beat wins over a same-cycle request drop so the load still completes.
                if (bus.LOAD_VALID && bus.LOAD_LAST) begin
                    state_d    = ST_RELEASE;
                    via_last_d = 1'b1;
                end else if (!bus.LOAD_REQ) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                load_done = via_last_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK_REF or negedge RST_N) begin
        if (!RST_N) begin
            misalign_q <= 1'b0;
            oor_q      <= 1'b0;
        end else if (bus.ERR_CLR) begin
            misalign_q <= 1'b0;
            oor_q      <= 1'b0;
        end else if ((state_q == ST_IDLE) && cpu_acc) begin
            if (bus.MEM_ACCESS_ADDRESS_BUS[IDX_LSB-1:0] != '0) misalign_q <= 1'b1;
            if (!cpu_in_range)                                 oor_q      <= 1'b1;
        end
    end

    assign bus.MEM_ACCESS_DATA_IN_BUS =
        ((state_q == ST_IDLE) && (bus.MEM_ACCESS_READ_WRN == MEM_READ) && cpu_in_range) ? mem_rdata : '0;
    assign bus.HALT         = halt;
    assign bus.LOAD_READY   = load_rdy;
    assign bus.LOAD_DONE    = load_done;
    assign bus.MISALIGN_ERR = misalign_q;
    assign bus.OOR_ERR      = oor_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + randomized bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

    localparam int AW    = 10;
    localparam int HS    = 1;
    localparam int DEPTH = 1 << AW;

    logic ck    = 1'b0;
    logic rst_n = 1'b0;
    always #5 ck = ~ck;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [DEPTH];
    bit          known   [DEPTH];
    int          b_idx   [8];
    logic [31:0] b_dat   [8];

    data_mem_responder_if #(.ADDR_WIDTH(AW)) bus ();

    data_mem_responder #(
        .ADDR_WIDTH  (AW),
        .HALT_SETTLE (HS)
    ) dut (
        .CK_REF (ck),
        .RST_N  (rst_n),
        .bus    (bus)
    );

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus.MEM_ACCESS_READ_WRN     = 1'b1;
        bus.MEM_ACCESS_ADDRESS_BUS  = 16'h0000;
        bus.MEM_ACCESS_DATA_OUT_BUS = 32'h0;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [31:0] d);
        int idx;
        bus.MEM_ACCESS_READ_WRN     = 1'b0;
        bus.MEM_ACCESS_ADDRESS_BUS  = addr;
        bus.MEM_ACCESS_DATA_OUT_BUS = d;
        step();
        idx = int'(addr) / 4;
        if (idx < DEPTH) begin
            ref_mem[idx] = d;
            known[idx]   = 1'b1;
        end
        bus_idle();
    endtask

    task automatic cpu_read(input logic [15:0] addr, input string tag);
        int          idx;
        logic [31:0] exp;
        bus.MEM_ACCESS_READ_WRN    = 1'b1;
        bus.MEM_ACCESS_ADDRESS_BUS = addr;
        #1;
        idx = int'(addr) / 4;
        exp = (idx < DEPTH) ? ref_mem[idx] : 32'h0;
        chk(tag, bus.MEM_ACCESS_DATA_IN_BUS, exp);
        step();
        bus_idle();
    endtask

    // Runs one loader session over b_idx/b_dat; optionally keeps a CPU store on the bus while halted.
    task automatic run_load(input int n, input bit with_last, input int hold_idx);
        bus.LOAD_REQ = 1'b1;
        #1;
        chk("halt_before_edge", bus.HALT, 1'b0);
        step();
        if (hold_idx >= 0) begin
            bus.MEM_ACCESS_READ_WRN     = 1'b0;
            bus.MEM_ACCESS_ADDRESS_BUS  = 16'(hold_idx * 4);
            bus.MEM_ACCESS_DATA_OUT_BUS = 32'hDEAD_BEEF;
        end
        chk("halt_rise", bus.HALT, 1'b1);
        for (int i = 0; i < HS; i++) begin
            chk("ready_in_settle", bus.LOAD_READY, 1'b0);
            step();
        end
        chk("ready_rise", bus.LOAD_READY, 1'b1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) step();
            bus.LOAD_VALID = 1'b1;
            bus.LOAD_ADDR  = AW'(b_idx[i]);
            bus.LOAD_DATA  = b_dat[i];
            bus.LOAD_LAST  = with_last && (i == n - 1);
            step();
            ref_mem[b_idx[i]] = b_dat[i];
            known[b_idx[i]]   = 1'b1;
        end
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_LAST  = 1'b0;
        bus_idle();
        if (!with_last) begin
            bus.LOAD_REQ = 1'b0;
            step();
        end
        chk("release_halt", bus.HALT, 1'b1);
        chk("release_ready", bus.LOAD_READY, 1'b0);
        chk("release_done", bus.LOAD_DONE, 32'(with_last));
        bus.LOAD_REQ = 1'b0;
        step();
        chk("halt_fall", bus.HALT, 1'b0);
        chk("done_single_pulse", bus.LOAD_DONE, 1'b0);
    endtask

    initial begin
        bus_idle();
        bus.LOAD_REQ   = 1'b0;
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_ADDR  = '0;
        bus.LOAD_DATA  = 32'h0;
        bus.LOAD_LAST  = 1'b0;
        bus.ERR_CLR    = 1'b0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        #2;
        chk("rst_halt", bus.HALT, 1'b0);
        chk("rst_ready", bus.LOAD_READY, 1'b0);
        chk("rst_done", bus.LOAD_DONE, 1'b0);
        chk("rst_misalign", bus.MISALIGN_ERR, 1'b0);
        chk("rst_oor", bus.OOR_ERR, 1'b0);
        #10 rst_n = 1'b1;
        step();

        // Basic store/load.
        cpu_write(16'h0010, 32'h1234_5678);
        cpu_read(16'h0010, "load_0x10");
        chk("no_misalign", bus.MISALIGN_ERR, 1'b0);
        chk("no_oor", bus.OOR_ERR, 1'b0);

        // Misaligned store still writes its word and raises the flag.
        cpu_write(16'h0012, 32'h5555_AAAA);
        chk("misalign_set", bus.MISALIGN_ERR, 1'b1);
        cpu_read(16'h0010, "misalign_data");
        bus.ERR_CLR = 1'b1;
        step();
        bus.ERR_CLR = 1'b0;
        chk("misalign_clr", bus.MISALIGN_ERR, 1'b0);

        // Clear beats a same-cycle set.
        bus.ERR_CLR = 1'b1;
        cpu_write(16'h0013, 32'h0BAD_F00D);
        bus.ERR_CLR = 1'b0;
        chk("clr_priority", bus.MISALIGN_ERR, 1'b0);

        // Out-of-range store must not alias onto word 0.
        cpu_write(16'h0000, 32'hCAFE_0000);
        cpu_write(16'h1000, 32'hBAD0_BAD0);
        chk("oor_set", bus.OOR_ERR, 1'b1);
        chk("oor_no_misalign", bus.MISALIGN_ERR, 1'b0);
        cpu_read(16'h1000, "oor_read_zero");
        cpu_read(16'h0000, "no_alias_word0");
        bus.ERR_CLR = 1'b1;
        step();
        bus.ERR_CLR = 1'b0;
        chk("oor_clr", bus.OOR_ERR, 1'b0);

        // Random aligned CPU traffic.
        for (int k = 0; k < 40; k++) begin
            int idx;
            idx = $urandom_range(0, 15);
            if (known[idx] && ($urandom_range(0, 1) == 1)) cpu_read(16'(idx * 4), "rand_load");
            else                                            cpu_write(16'(idx * 4), $urandom);
        end
        chk("rand_no_misalign", bus.MISALIGN_ERR, 1'b0);
        chk("rand_no_oor", bus.OOR_ERR, 1'b0);

        // Loader burst A0..A3 with a CPU store coinciding with REQ and another held during halt.
        cpu_write(16'h0024, 32'h9999_9999);
        for (int i = 0; i < 4; i++) begin
            b_idx[i] = i;
            b_dat[i] = 32'hA0 + 32'(i);
        end
        bus.MEM_ACCESS_READ_WRN     = 1'b0;
        bus.MEM_ACCESS_ADDRESS_BUS  = 16'h0020;
        bus.MEM_ACCESS_DATA_OUT_BUS = 32'h8888_8888;
        ref_mem[8] = 32'h8888_8888;
        known[8]   = 1'b1;
        run_load(4, 1'b1, 9);
        for (int i = 0; i < 4; i++) cpu_read(16'(i * 4), "loaded_word");
        cpu_read(16'h0020, "store_with_req");
        cpu_read(16'h0024, "held_store_ignored");

        // Random loader burst.
        begin
            int n;
            n = $urandom_range(2, 6);
            for (int i = 0; i < n; i++) begin
                b_idx[i] = $urandom_range(0, 15);
                b_dat[i] = $urandom;
            end
            run_load(n, 1'b1, -1);
        end
        for (int i = 0; i < 16; i++) if (known[i]) cpu_read(16'(i * 4), "rand_burst_word");

        // Request dropped mid-load: RELEASE without LOAD_DONE.
        b_idx[0] = 5;
        b_dat[0] = 32'hB5;
        run_load(1, 1'b0, -1);
        cpu_read(16'h0014, "abort_beat_kept");

        // Asynchronous reset between beats 1 and 2.
        bus.LOAD_REQ = 1'b1;
        step();
        repeat (HS) step();
        chk("rst_mid_ready", bus.LOAD_READY, 1'b1);
        for (int i = 0; i < 2; i++) begin
            bus.LOAD_VALID = 1'b1;
            bus.LOAD_ADDR  = AW'(i);
            bus.LOAD_DATA  = 32'hC0 + 32'(i);
            step();
            ref_mem[i] = 32'hC0 + 32'(i);
            known[i]   = 1'b1;
        end
        bus.LOAD_VALID = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_halt", bus.HALT, 1'b0);
        chk("async_rst_ready", bus.LOAD_READY, 1'b0);
        bus.LOAD_REQ = 1'b0;
        #2 rst_n = 1'b1;
        step();
        chk("post_rst_halt", bus.HALT, 1'b0);
        cpu_read(16'h0000, "retained_beat0");
        cpu_read(16'h0004, "retained_beat1");
        cpu_read(16'h0008, "untouched_word2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
